// File: rtl/spatz_vcfg_ctrl.sv
// spatz_vcfg_ctrl: executes vset* and vector CSR accesses, holding vl/vtype/vstart
// and deferring every configuration change until the vector datapath has drained.
module spatz_vcfg_ctrl #(
    parameter int VLEN = 512,
    parameter int ELEN = 32,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [31:0]     req_instr_i,
    input  logic [31:0]     req_rs1_i,
    input  logic [31:0]     req_rs2_i,
    input  logic [11:0]     req_csr_i,
    input  logic            vec_idle_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_data_o,
    output logic            rsp_err_o,
    output logic [8:0]      vtype_o,
    output logic [VL_W-1:0] vl_o,
    output logic [VL_W-1:0] vstart_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    localparam logic [1:0] OP_VSET = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2;
    localparam logic [11:0] CSR_VSTART = 12'h008, CSR_VL = 12'hC20, CSR_VTYPE = 12'hC21, CSR_VLENB = 12'hC22;
    localparam logic [31:0] VLEN_U = 32'(VLEN), ELEN_U = 32'(ELEN), VLENB = 32'(VLEN / 8);
    state_e state, state_d;
    logic [1:0] op;
    logic [31:0] instr, rs1, rs2;
    logic [11:0] csr;
    logic [8:0] vtype_d;
    logic [VL_W-1:0] vl_d, vstart_d, new_vl;
    logic [31:0] data_d, vt, sew, frac_cap, vlmax, avl, csr_rdata;
    logic [2:0] vsew, vlmul, frac_sh;
    logic err_d, is_vli, is_vili, is_vl, bad_vset, bad_csr, err, drain, vill;
    assign is_vli   = !instr[31];
    assign is_vili  = instr[31:30] == 2'b11;
    assign is_vl    = instr[31:25] == 7'b1000000;
    assign bad_vset = instr[6:0] != 7'b1010111 || instr[14:12] != 3'b111 || !(is_vli || is_vili || is_vl);
    assign vt       = is_vl ? rs2 : is_vili ? {22'd0, instr[29:20]} : {21'd0, instr[30:20]};
    assign vsew     = vt[5:3];
    assign vlmul    = vt[2:0];
    // fractional LMUL 1/8,1/4,1/2 encodes as 5,6,7, so the divide shift is -vlmul mod 8
    assign frac_sh  = 3'd0 - vlmul;
    assign sew      = 32'd8 << vsew[1:0];
    assign frac_cap = ELEN_U >> frac_sh;
    assign vill     = |vt[31:8] || vsew[2] || sew > ELEN_U || vlmul == 3'b100 || (vlmul[2] && sew > frac_cap);
    assign vlmax    = vlmul[2] ? (VLEN_U >> (vsew[1:0] + 3'd3)) >> frac_sh
                               : (VLEN_U >> (vsew[1:0] + 3'd3)) << vlmul[1:0];
    assign avl      = is_vili ? {27'd0, instr[19:15]} : instr[19:15] != 5'd0 ? rs1
                    : instr[11:7] != 5'd0 ? '1 : 32'(vl_o);
    assign new_vl   = avl < vlmax ? avl[VL_W-1:0] : vlmax[VL_W-1:0];
    assign csr_rdata = csr == CSR_VL ? 32'(vl_o) : csr == CSR_VTYPE ? {vtype_o[8], 23'd0, vtype_o[7:0]}
                     : csr == CSR_VLENB ? VLENB : 32'(vstart_o);
    assign bad_csr  = op == OP_WR ? csr != CSR_VSTART
                    : !(csr == CSR_VSTART || csr == CSR_VL || csr == CSR_VTYPE || csr == CSR_VLENB);
    assign err      = op == 2'd3 || (op == OP_VSET ? bad_vset : bad_csr);
    assign drain    = !err && op != OP_RD;
    assign req_ready_o = state == IDLE;
    assign rsp_valid_o = state == RESP;
    always_comb begin
        state_d  = state;
        vtype_d  = vtype_o;
        vl_d     = vl_o;
        vstart_d = vstart_o;
        data_d   = rsp_data_o;
        err_d    = rsp_err_o;
        case (state)
            IDLE: state_d = req_valid_i ? EXEC : IDLE;
            EXEC: if (!drain || vec_idle_i) begin
                state_d = RESP;
                err_d   = err;
                data_d  = err ? '0 : op == OP_VSET ? (vill ? '0 : 32'(new_vl))
                        : op == OP_RD ? csr_rdata : 32'(vstart_o);
                if (drain && op == OP_VSET) begin
                    vtype_d  = vill ? 9'h100 : {1'b0, vt[7:0]};
                    vl_d     = vill ? '0 : new_vl;
                    vstart_d = '0;
                end
                if (drain && op == OP_WR) vstart_d = rs1[VL_W-1:0];
            end
            RESP: state_d = rsp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            vtype_o    <= 9'h100;
            vl_o       <= '0;
            vstart_o   <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            state      <= state_d;
            vtype_o    <= vtype_d;
            vl_o       <= vl_d;
            vstart_o   <= vstart_d;
            rsp_data_o <= data_d;
            rsp_err_o  <= err_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_valid_i) begin
            op    <= req_op_i;
            instr <= req_instr_i;
            rs1   <= req_rs1_i;
            rs2   <= req_rs2_i;
            csr   <= req_csr_i;
        end
    end
endmodule
